// File: rtl/seg_display_ctrl.sv
// 4-digit 7-segment controller: sequential double-dabble of the score, digit
// multiplexing, and the game-over YOU / LOSE / score-blink message sequence.
module seg_display_ctrl #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_state,
  input  logic [10:0] score,
  output logic [3:0]  Anode_Activate,
  output logic [6:0]  LED_out,
  output logic        bcd_valid
);

  localparam int SCAN_W  = $clog2(SCAN_DIV + 1);
  localparam int BLINK_W = $clog2(BLINK_DIV + 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_Y     = 7'b1000100;
  localparam logic [6:0] SEG_O     = 7'b0000001;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_L     = 7'b1110001;
  localparam logic [6:0] SEG_S     = 7'b0100100;
  localparam logic [6:0] SEG_E     = 7'b0110000;

  typedef enum logic {S_IDLE, S_CONV} state_t;

  function automatic logic [6:0] bcd_glyph(input logic [3:0] d);
    case (d)
      4'd1:    bcd_glyph = 7'b1001111;
      4'd2:    bcd_glyph = 7'b0010010;
      4'd3:    bcd_glyph = 7'b0000110;
      4'd4:    bcd_glyph = 7'b1001100;
      4'd5:    bcd_glyph = 7'b0100100;
      4'd6:    bcd_glyph = 7'b0100000;
      4'd7:    bcd_glyph = 7'b0001111;
      4'd8:    bcd_glyph = 7'b0000000;
      4'd9:    bcd_glyph = 7'b0000100;
      default: bcd_glyph = 7'b0000001;
    endcase
  endfunction

  logic [SCAN_W-1:0]  r_scan_cnt;
  logic [1:0]         r_idx;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic [3:0]         r_phase;

  state_t      r_state, w_state_next;
  logic [10:0] r_last_score;
  logic [10:0] r_shift;
  logic [15:0] r_acc;
  logic [15:0] w_adj;
  logic [3:0]  r_bit_cnt;
  logic [15:0] r_dig;
  logic        r_bcd_valid;
  logic        w_score_changed;

  logic [3:0]  w_digit;
  logic [3:0]  w_anode;
  logic [6:0]  w_score_seg;
  logic [6:0]  w_seg;

  // NOTE: every clocked block uses <= so all registers sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
    end else if (r_scan_cnt == SCAN_LAST) begin
      r_scan_cnt <= '0;
      r_idx      <= r_idx + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_phase     <= '0;
    end else if (game_state) begin
      r_blink_cnt <= '0;
      r_phase     <= '0;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt <= '0;
      r_phase     <= (r_phase == 4'd8) ? 4'd0 : r_phase + 4'd1;
    end else begin
      r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
    end
  end

  assign w_score_changed = (score != r_last_score);

  // NOTE: combinational blocks assign a default first so no path infers a latch.
  always_comb begin
    w_adj = r_acc;
    for (int i = 0; i < 4; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_score_changed) w_state_next = S_CONV;
      S_CONV:  if (r_bit_cnt == 4'd11) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Scores arriving mid-conversion are ignored; IDLE picks up the mismatch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_score <= '0;
      r_shift      <= '0;
      r_acc        <= '0;
      r_bit_cnt    <= '0;
      r_dig        <= '0;
      r_bcd_valid  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_bcd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_score_changed) begin
            r_last_score <= score;
            r_shift      <= score;
            r_acc        <= '0;
            r_bit_cnt    <= '0;
          end
        end
        S_CONV: begin
          if (r_bit_cnt == 4'd11) begin
            r_dig       <= r_acc;
            r_bcd_valid <= 1'b1;
          end else begin
            {r_acc, r_shift} <= {w_adj, r_shift} << 1;
            r_bit_cnt        <= r_bit_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_digit = r_dig[15:12];
    w_anode = 4'b0111;
    case (r_idx)
      2'd0: begin w_digit = r_dig[15:12]; w_anode = 4'b0111; end
      2'd1: begin w_digit = r_dig[11:8];  w_anode = 4'b1011; end
      2'd2: begin w_digit = r_dig[7:4];   w_anode = 4'b1101; end
      2'd3: begin w_digit = r_dig[3:0];   w_anode = 4'b1110; end
      default: ;
    endcase
  end

  assign w_score_seg = bcd_glyph(w_digit);

  always_comb begin
    w_seg = w_score_seg;
    if (!game_state) begin
      case (r_phase)
        4'd0: case (r_idx)
          2'd0:    w_seg = SEG_BLANK;
          2'd1:    w_seg = SEG_Y;
          2'd2:    w_seg = SEG_O;
          default: w_seg = SEG_U;
        endcase
        4'd2: case (r_idx)
          2'd0:    w_seg = SEG_L;
          2'd1:    w_seg = SEG_O;
          2'd2:    w_seg = SEG_S;
          default: w_seg = SEG_E;
        endcase
        4'd4, 4'd5, 4'd6, 4'd8: w_seg = w_score_seg;
        default: w_seg = SEG_BLANK;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Anode_Activate <= 4'b1111;
      LED_out        <= SEG_BLANK;
    end else begin
      Anode_Activate <= w_anode;
      LED_out        <= w_seg;
    end
  end

  assign bcd_valid = r_bcd_valid;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl: directed vector table, hand-written corner
// sequences, and random stimulus against a text-level display model.
module tb_seg_display_ctrl;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 8;

  localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010,
                         G3 = 7'b0000110, G4 = 7'b1001100, G5 = 7'b0100100,
                         G7 = 7'b0001111, G9 = 7'b0000100, GB = 7'b1111111;
  localparam logic [3:0] SCAN_SEQ [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  logic        clk;
  logic        rst;
  logic        game_state;
  logic [10:0] score;
  logic [3:0]  Anode_Activate;
  logic [6:0]  LED_out;
  logic        bcd_valid;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  seg_display_ctrl #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk            (clk),
    .rst            (rst),
    .game_state     (game_state),
    .score          (score),
    .Anode_Activate (Anode_Activate),
    .LED_out        (LED_out),
    .bcd_valid      (bcd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] char_glyph(input byte c);
    case (c)
      "0", "O": return 7'b0000001;
      "1":      return 7'b1001111;
      "2":      return 7'b0010010;
      "3":      return 7'b0000110;
      "4":      return 7'b1001100;
      "5", "S": return 7'b0100100;
      "6":      return 7'b0100000;
      "7":      return 7'b0001111;
      "8":      return 7'b0000000;
      "9":      return 7'b0000100;
      "Y":      return 7'b1000100;
      "U":      return 7'b1000001;
      "L":      return 7'b1110001;
      "E":      return 7'b0110000;
      default:  return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] expected_seg(input bit playing, input int phase,
                                              input int value, input int idx);
    string txt;
    if (playing || phase == 4 || phase == 5 || phase == 6 || phase == 8)
      txt = $sformatf("%04d", value);
    else if (phase == 0) txt = " YOU";
    else if (phase == 2) txt = "LOSE";
    else                 txt = "    ";
    return char_glyph(txt[idx]);
  endfunction

  function automatic int anode_idx(input logic [3:0] an);
    case (an)
      4'b0111: return 0;
      4'b1011: return 1;
      4'b1101: return 2;
      4'b1110: return 3;
      default: return -1;
    endcase
  endfunction

  // Reference model: display position from elapsed cycles, message phase from
  // cycles spent in game-over, and committed value 12 cycles after each capture.
  int   m_k, m_go, m_last, m_cap, m_shown, m_done;
  bit   m_busy;
  logic [3:0] exp_an;
  logic [6:0] exp_led;
  logic       exp_valid;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k <= 0; m_go <= 0; m_last <= 0; m_cap <= 0; m_shown <= 0; m_done <= 0;
      m_busy <= 1'b0; exp_an <= 4'b1111; exp_led <= 7'b1111111; exp_valid <= 1'b0;
    end else begin
      exp_an    <= 4'b1111 ^ (4'b1000 >> ((m_k / SCAN_DIV) % 4));
      exp_led   <= expected_seg(game_state, (m_go / BLINK_DIV) % 9, m_shown,
                                (m_k / SCAN_DIV) % 4);
      m_k       <= m_k + 1;
      m_go      <= game_state ? 0 : m_go + 1;
      exp_valid <= 1'b0;
      if (m_busy) begin
        if (m_k == m_done) begin
          m_shown   <= m_cap;
          m_busy    <= 1'b0;
          exp_valid <= 1'b1;
        end
      end else if (int'(score) != m_last) begin
        m_last <= int'(score);
        m_cap  <= int'(score);
        m_busy <= 1'b1;
        m_done <= m_k + 12;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("model_anode", Anode_Activate, exp_an);
      check("model_led", LED_out, exp_led);
      check("model_valid", bcd_valid, exp_valid);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [10:0]     score;
    logic [3:0][6:0] seg;   // seg[3] = leftmost digit
  } vec_t;

  vec_t       vec [8];
  int         lat, first_p, second_p, pulses, idx, p;
  logic [6:0] got [4];
  string      txt;
  string      phase_txt [9];

  task automatic wait_valid(output int latency);
    latency = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bcd_valid) begin
        latency = i;
        break;
      end
    end
  endtask

  task automatic capture_digits();
    for (int d = 0; d < 4; d++) got[d] = 7'b0000000;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (anode_idx(Anode_Activate) >= 0) got[anode_idx(Anode_Activate)] = LED_out;
    end
  endtask

  initial begin
    vec[0] = '{11'd1234, {G1, G2, G3, G4}};
    vec[1] = '{11'd2047, {G2, G0, G4, G7}};
    vec[2] = '{11'd5,    {G0, G0, G0, G5}};
    vec[3] = '{11'd999,  {G0, G9, G9, G9}};
    vec[4] = '{11'd1000, {G1, G0, G0, G0}};
    vec[5] = '{11'd2000, {G2, G0, G0, G0}};
    vec[6] = '{11'd10,   {G0, G0, G1, G0}};
    vec[7] = '{11'd0,    {G0, G0, G0, G0}};
    phase_txt = '{" YOU", "    ", "LOSE", "    ", "0009", "0009", "0009", "    ", "0009"};

    rst = 1'b1; game_state = 1'b1; score = 11'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_anode", Anode_Activate, 4'b1111);
    check("rst_led", LED_out, 7'b1111111);
    check("rst_valid", bcd_valid, 1'b0);
    #2 rst = 1'b0;
    chk_en = 1'b1;

    // Idle after reset with score 0: no conversion, digits 0000, anode scan.
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("scan_anode", Anode_Activate, SCAN_SEQ[k / 4]);
      check("idle_led", LED_out, G0);
      check("idle_valid", bcd_valid, 1'b0);
    end

    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      score = vec[v].score;
      wait_valid(lat);
      check("vec_latency", lat, 12);
      capture_digits();
      for (int d = 0; d < 4; d++) check($sformatf("vec%0d_digit%0d", v, d), got[d], vec[v].seg[3-d]);
    end

    // Score 5 then 9 three cycles later: two commits, 13 cycles apart.
    @(negedge clk);
    score = 11'd5;
    pulses = 0; first_p = -1; second_p = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 2) score = 11'd9;
      if (bcd_valid) begin
        pulses++;
        if (first_p < 0) first_p = i; else second_p = i;
      end
    end
    check("dbl_pulses", pulses, 2);
    check("dbl_first", first_p, 12);
    check("dbl_second", second_p, 25);

    // Game over message sequence with score 0009.
    @(negedge clk);
    game_state = 1'b0;
    for (int i = 0; i <= 80; i++) begin
      @(negedge clk);
      if (i % 8 == 0 || i % 8 == 7) begin
        p   = (i / 8) % 9;
        txt = phase_txt[p];
        idx = anode_idx(Anode_Activate);
        check($sformatf("msg_anode_%0d", i), idx >= 0, 1'b1);
        if (idx >= 0) check($sformatf("msg_led_%0d", i), LED_out, char_glyph(txt[idx]));
      end
    end
    game_state = 1'b1;
    @(negedge clk);
    idx = anode_idx(Anode_Activate);
    check("resume_led", LED_out, (idx == 3) ? G9 : G0);

    // Reset five cycles into a conversion of 777.
    @(negedge clk);
    score = 11'd777;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_anode", Anode_Activate, 4'b1111);
    check("abort_led", LED_out, GB);
    check("abort_valid", bcd_valid, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("post_rst_anode", Anode_Activate, 4'b0111);
    lat = -1;
    for (int i = 1; i < 40; i++) begin
      @(negedge clk);
      if (bcd_valid) begin
        lat = i;
        break;
      end
      check("post_rst_zero", LED_out, G0);
    end
    check("post_rst_latency", lat, 12);
    capture_digits();
    check("r777_d0", got[0], G0);
    check("r777_d1", got[1], G7);
    check("r777_d2", got[2], G7);
    check("r777_d3", got[3], G7);

    // Random traffic checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      p = $urandom_range(0, 99);
      if (p < 5) score = 11'($urandom_range(0, 2047));
      else if (p < 7) game_state = ~game_state;
      else if (p == 7 && $urandom_range(0, 9) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
